rx: RTL and testbench

Parameterized asynchronous UART receiver and the downstream partner of the `tx` transmitter. It synchronizes the serial line and detects the start bit, then samples each bit at mid-period. It reassembles an 8-bit byte and reports it with a one-cycle strobe plus parity and framing status. The frame format matches `tx`: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).

---
 rtl/rx.sv | 163 ++++++++++++++++
 tb/tb_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
`default_nettype none
// ============================================================================
// Module   : rx
// Brief    : Asynchronous UART receiver. 1 start, 8 data (LSB first),
//            1 parity, 1 stop bit. Mid-bit sampling, one-cycle data strobe
//            with parity and framing status.
// Revision : 1.0 - initial release
// ============================================================================
module rx #(
    parameter int CLK_FREQ    = 100000000,
    parameter int BAUD_RATE   = 19200,
    parameter int PARITY_MODE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] dout,
    output logic       data_strobe,
    output logic       parity_error,
    output logic       frame_error,
    output logic       busy
);

    localparam int c_timer_max_int = CLK_FREQ / BAUD_RATE;
    localparam int c_tw            = $clog2(c_timer_max_int + 1);
    localparam logic [c_tw-1:0] c_timer_max  = c_tw'(c_timer_max_int);
    localparam logic [c_tw-1:0] c_timer_half = c_tw'(c_timer_max_int / 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic            s1_q, s2_q, prev_q;
    state_t          state_q, state_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [7:0]      dout_q, dout_d;
    logic            strobe_q, strobe_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;

    logic            w_at_max;
    logic            w_at_half;
    logic            w_par_exp;

    assign w_at_max  = (timer_q == c_timer_max);
    assign w_at_half = (timer_q == c_timer_half);
    // Parity the transmitter would have generated for the assembled byte
    assign w_par_exp = (PARITY_MODE == 1) ? ~^shift_q : ^shift_q;

    // Two-flop synchronizer plus previous-value flop for falling-edge detect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= rx_in;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            dout_q   <= 8'h00;
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state, baud timer, bit sampling and result capture
    always_comb begin
        state_d  = state_q;
        timer_d  = w_at_max ? '0 : timer_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        perr_d   = perr_q;
        ferr_d   = ferr_q;

        case (state_q)
            S_IDLE: begin
                // Timer held at zero so START always begins from a fresh count
                timer_d = '0;
                if (!s2_q && prev_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (w_at_half) begin
                    if (!s2_q) begin
                        state_d = S_DATA;
                        timer_d = '0;
                        bit_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_at_max) begin
                    shift_d[bit_q] = s2_q;
                    bit_d          = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_max) begin
                    par_d   = s2_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_at_max) begin
                    state_d  = S_IDLE;
                    dout_d   = shift_q;
                    perr_d   = (par_q != w_par_exp);
                    ferr_d   = ~s2_q;
                    strobe_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dout         = dout_q;
    assign data_strobe  = strobe_q;
    assign parity_error = perr_q;
    assign frame_error  = ferr_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx
// Brief    : Self-checking bench for rx. Bit-banged frames on a shared line
//            feed an odd-parity and an even-parity receiver; expected results
//            are queued at send time and popped by a strobe monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx;

    localparam int c_p = 11;  // bit period in cycles at 1000 Hz / 100 baud

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] dout_o, dout_e;
    logic       stb_o, stb_e;
    logic       pe_o, pe_e;
    logic       fe_o, fe_e;
    logic       busy_o, busy_e;

    exp_t q_odd[$];
    exp_t q_even[$];
    int   n_checks;
    int   n_fail;
    logic prev_stb_o, prev_stb_e;

    rx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_MODE(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .dout(dout_o),
        .data_strobe(stb_o), .parity_error(pe_o), .frame_error(fe_o),
        .busy(busy_o)
    );

    rx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_MODE(0)) dut_e (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .dout(dout_e),
        .data_strobe(stb_e), .parity_error(pe_e), .frame_error(fe_e),
        .busy(busy_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the odd-parity receiver
    always @(negedge clk) begin
        if (stb_o === 1'b1) begin
            check("odd_no_double_strobe", {31'd0, prev_stb_o}, 32'd0);
            if (q_odd.size() == 0) begin
                check("odd_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_odd.pop_front();
                check("odd_dout", {24'd0, dout_o}, {24'd0, e.d});
                check("odd_parity_error", {31'd0, pe_o}, {31'd0, e.pe});
                check("odd_frame_error", {31'd0, fe_o}, {31'd0, e.fe});
                check("odd_busy_in_strobe", {31'd0, busy_o}, 32'd0);
            end
        end
        prev_stb_o <= stb_o;
    end

    // Scoreboard monitor for the even-parity receiver
    always @(negedge clk) begin
        if (stb_e === 1'b1) begin
            check("even_no_double_strobe", {31'd0, prev_stb_e}, 32'd0);
            if (q_even.size() == 0) begin
                check("even_unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_even.pop_front();
                check("even_dout", {24'd0, dout_e}, {24'd0, e.d});
                check("even_parity_error", {31'd0, pe_e}, {31'd0, e.pe});
                check("even_frame_error", {31'd0, fe_e}, {31'd0, e.fe});
            end
        end
        prev_stb_e <= stb_e;
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        cycles(c_p);
    endtask

    // Send one frame; expected results are given by hand per receiver
    task automatic send(input logic [7:0] d, input logic par, input logic stop,
                        input logic pe_odd, input logic pe_even);
        exp_t eo, ee;
        eo.d = d; eo.pe = pe_odd;  eo.fe = ~stop;
        ee.d = d; ee.pe = pe_even; ee.fe = ~stop;
        q_odd.push_back(eo);
        q_even.push_back(ee);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        int          seen;
        logic [7:0]  partial;
        n_checks   = 0;
        n_fail     = 0;
        prev_stb_o = 1'b0;
        prev_stb_e = 1'b0;
        rx_in      = 1'b1;
        rst_n      = 1'b0;
        cycles(3);
        rst_n = 1'b1;

        // Reset state
        check("rst_dout", {24'd0, dout_o}, 32'd0);
        check("rst_strobe", {31'd0, stb_o}, 32'd0);
        check("rst_parity_error", {31'd0, pe_o}, 32'd0);
        check("rst_frame_error", {31'd0, fe_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        cycles(5);

        // 0xA5: four ones -> odd parity bit 1 (even receiver sees a mismatch)
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(5);
        check("a5_busy_after", {31'd0, busy_o}, 32'd0);
        cycles(10);

        // Back-to-back even-parity frames: 0x00 p0, 0xFF p0, 0x01 p1
        send(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0);
        send(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
        cycles(20);

        // Short glitch: busy pulses then drops at the half-bit check
        rx_in = 1'b0;
        cycles(3);
        rx_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 6 && seen == 0; i++) begin
            if (busy_o) seen = 1;
            else cycles(1);
        end
        check("glitch_busy_rises", seen, 1);
        seen = 0;
        for (int i = 0; i < 12 && seen == 0; i++) begin
            if (!busy_o) seen = 1;
            else cycles(1);
        end
        check("glitch_busy_falls", seen, 1);
        cycles(30);
        check("glitch_dout_held", {24'd0, dout_o}, 32'h01);

        // 0x3C with inverted parity (sent 0), then good 0x81 clears the flag
        send(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        cycles(5);
        check("3c_perr_held", {31'd0, pe_o}, 32'd1);
        send(8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(5);
        check("81_perr_cleared", {31'd0, pe_o}, 32'd0);

        // 0x55 with stop bit 0, line held low, then valid 0x12
        send(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        cycles(50);
        check("55_ferr_held", {31'd0, fe_o}, 32'd1);
        check("55_busy_low", {31'd0, busy_o}, 32'd0);
        rx_in = 1'b1;
        cycles(15);
        send(8'h12, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(5);
        check("12_ferr_cleared", {31'd0, fe_o}, 32'd0);
        cycles(10);

        // Reset during data bit 4 of a 0xC3 frame abandons it
        partial = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx_in = partial[4];
        cycles(5);
        check("midframe_busy_before_rst", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        rx_in = 1'b1;
        cycles(1);
        rst_n = 1'b1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_dout", {24'd0, dout_o}, 32'd0);
        check("midrst_parity_error", {31'd0, pe_o}, 32'd0);
        check("midrst_frame_error", {31'd0, fe_o}, 32'd0);
        check("midrst_strobe", {31'd0, stb_o}, 32'd0);
        cycles(150);
        send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(20);

        // Every queued frame must have been strobed out
        check("odd_queue_drained", q_odd.size(), 0);
        check("even_queue_drained", q_even.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
